// File: rtl/dram_read_bridge.sv
// DRAM read bridge: accepts read addresses, issues them to a fixed-latency backend and
// returns lines in order through a credit-reserved FIFO. Define DRAM_READ_BRIDGE_STAT_EN for counters.
module dram_read_bridge #(
  parameter int unsigned GBW   = 32,
  parameter int unsigned DBW   = 16,
  parameter int unsigned CSIZE = 32,
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   dramra_rdy,
  output logic                   dramra_ack,
  input  logic [GBW-1:0]         i_dramra,
  output logic                   dramrd_rdy,
  input  logic                   dramrd_ack,
  output logic [CSIZE*DBW-1:0]   o_dramrd,
  output logic                   o_mem_ce,
  output logic [GBW-1:0]         o_mem_addr,
  input  logic [CSIZE*DBW-1:0]   i_mem_rdata
`ifdef DRAM_READ_BRIDGE_STAT_EN
  ,
  output logic [31:0]            o_stat_reqs,
  output logic [31:0]            o_stat_stall
`endif
);

  localparam int unsigned LW = CSIZE * DBW;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned VW = (LAT > 1) ? LAT - 1 : 1;

  logic          alive_q, alive_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [VW-1:0] vpipe_q, vpipe_d;
  logic [LW-1:0] mem_q [DEPTH];
  logic [LW-1:0] mem_d [DEPTH];

  logic [CW-1:0] free_c;
  logic          vout_c;
  logic          push_c;
  logic          pop_c;

  // Request path: accept only against a reserved FIFO slot, issue in the same cycle.
  always_comb begin
    free_c     = CW'(DEPTH) - count_q - inflight_q;
    dramra_ack = alive_q & dramra_rdy & (free_c != '0);
    o_mem_ce   = dramra_ack;
    o_mem_addr = dramra_ack ? i_dramra : '0;
    dramrd_rdy = (count_q != '0);
    o_dramrd   = mem_q[rptr_q];
  end

  // The strobe itself is stage 0 of the valid pipe; the tail marks the capture
  // cycle so the line is written on the LAT-th edge after the strobe cycle.
  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = o_mem_ce;
    for (int i = 1; i < int'(VW); i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
    vout_c = (LAT > 1) ? vpipe_q[VW-1] : o_mem_ce;
    push_c = vout_c;
    pop_c  = dramrd_ack & dramrd_rdy;
  end

  always_comb begin
    alive_d    = 1'b1;
    count_d    = count_q;
    inflight_d = inflight_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    mem_d      = mem_q;

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case ({o_mem_ce, vout_c})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (push_c) begin
      mem_d[wptr_q] = i_mem_rdata;
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alive_q    <= 1'b0;
      count_q    <= '0;
      inflight_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      vpipe_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      alive_q    <= alive_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      vpipe_q    <= vpipe_d;
      mem_q      <= mem_d;
    end
  end

`ifdef DRAM_READ_BRIDGE_STAT_EN
  logic [31:0] stat_reqs_q, stat_reqs_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Saturating event counters.
  always_comb begin
    stat_reqs_d  = stat_reqs_q;
    stat_stall_d = stat_stall_q;
    if (o_mem_ce && (stat_reqs_q != '1)) begin
      stat_reqs_d = stat_reqs_q + 32'd1;
    end
    if (alive_q && dramra_rdy && !dramra_ack && (stat_stall_q != '1)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stat_reqs_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_reqs_q  <= stat_reqs_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign o_stat_reqs  = stat_reqs_q;
  assign o_stat_stall = stat_stall_q;
`endif

endmodule
